// File: rtl/ccip_arb_pkg.sv
// Shared constants and types for the two-port c0 read arbiter.
package ccip_arb_pkg;

  localparam int unsigned ARB_DEPTH  = 16;
  localparam int unsigned ARB_SLACK  = 4;
  // mdata bit that carries the requester ID through the channel.
  localparam int unsigned ARB_ID_BIT = 15;

  typedef logic [0:0] t_arb_port;

endpackage

// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel-0 header and data types used by the read arbiter.
// Field layout follows the CCI-P c0 request/response memory headers.
package ccip_if_pkg;

  typedef logic [511:0] t_ccip_clData;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    logic [1:0]   cl_len;
    logic [3:0]   req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c0_RspMemHdr;

endpackage

// File: rtl/ccip_arb_req_fifo.sv
// Single-clock request FIFO holding c0 request headers for one arbiter port.
// Writes to a full FIFO are dropped; reads to an empty FIFO are ignored.
module ccip_arb_req_fifo
  import ccip_if_pkg::*;
  import ccip_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = ARB_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  t_ccip_c0_ReqMemHdr wr_data_i,
  input  logic               rd_en_i,
  output t_ccip_c0_ReqMemHdr rd_data_o,
  output logic [CW-1:0]      count_o,
  output logic               full_o,
  output logic               empty_o
);

  t_ccip_c0_ReqMemHdr mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               push, pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// Two-port round-robin arbiter sharing one CCI-P c0 read-request path.
// Tags requester ID into mdata[15] on requests and steers responses back by it.
module ccip_c0_rd_arbiter
  import ccip_if_pkg::*;
  import ccip_arb_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_DEPTH,
  parameter int unsigned SLACK = ARB_SLACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  t_ccip_c0_ReqMemHdr req_hdr [2],
  output logic [1:0]         req_almfull,
  output logic               c0_tx_valid,
  output t_ccip_c0_ReqMemHdr c0_tx_hdr,
  input  logic               c0_tx_almfull,
  input  logic               c0_rx_rspvalid,
  input  t_ccip_c0_RspMemHdr c0_rx_hdr,
  input  t_ccip_clData       c0_rx_data,
  output logic [1:0]         rsp_valid,
  output t_ccip_c0_RspMemHdr rsp_hdr,
  output t_ccip_clData       rsp_data,
  output logic [1:0]         ovf_err
);

  localparam int unsigned   CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ALMFULL_THR = CW'(DEPTH - SLACK);

  t_ccip_c0_ReqMemHdr fifo_rd_hdr [2];
  logic [CW-1:0]      fifo_count  [2];
  logic [1:0]         fifo_full, fifo_empty, pop;

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    ccip_arb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (req_valid[p]),
      .wr_data_i (req_hdr[p]),
      .rd_en_i   (pop[p]),
      .rd_data_o (fifo_rd_hdr[p]),
      .count_o   (fifo_count[p]),
      .full_o    (fifo_full[p]),
      .empty_o   (fifo_empty[p])
    );
  end

  t_arb_port          last_grant_q, winner, rsp_port;
  logic               grant;
  t_ccip_c0_ReqMemHdr tx_hdr_d;
  t_ccip_c0_RspMemHdr rsp_hdr_d;
  logic [1:0]         rsp_valid_d, almfull_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant  = !c0_tx_almfull && (fifo_empty != 2'b11);
    winner = ~last_grant_q;
    if (fifo_empty[0])      winner = 1'b1;
    else if (fifo_empty[1]) winner = 1'b0;
    pop = '0;
    if (grant) pop[winner] = 1'b1;
    tx_hdr_d = fifo_rd_hdr[winner];
    tx_hdr_d.mdata[ARB_ID_BIT] = winner;

    rsp_port  = c0_rx_hdr.mdata[ARB_ID_BIT];
    rsp_hdr_d = c0_rx_hdr;
    rsp_hdr_d.mdata[ARB_ID_BIT] = 1'b0;
    rsp_valid_d = '0;
    if (c0_rx_rspvalid) rsp_valid_d[rsp_port] = 1'b1;

    for (int p = 0; p < 2; p++) begin
      almfull_d[p] = (fifo_count[p] >= ALMFULL_THR) || c0_tx_almfull;
    end
  end

  logic               c0_tx_valid_q;
  t_ccip_c0_ReqMemHdr c0_tx_hdr_q;
  logic [1:0]         req_almfull_q, ovf_err_q, rsp_valid_q;
  t_ccip_c0_RspMemHdr rsp_hdr_q;
  t_ccip_clData       rsp_data_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q  <= 1'b1;
      c0_tx_valid_q <= 1'b0;
      c0_tx_hdr_q   <= '0;
      req_almfull_q <= 2'b11;
      ovf_err_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_hdr_q     <= '0;
      rsp_data_q    <= '0;
    end else begin
      c0_tx_valid_q <= grant;
      if (grant) begin
        last_grant_q <= winner;
        c0_tx_hdr_q  <= tx_hdr_d;
      end
      req_almfull_q <= almfull_d;
      ovf_err_q     <= ovf_err_q | (req_valid & fifo_full);
      rsp_valid_q   <= rsp_valid_d;
      if (c0_rx_rspvalid) begin
        rsp_hdr_q  <= rsp_hdr_d;
        rsp_data_q <= c0_rx_data;
      end
    end
  end

  assign c0_tx_valid = c0_tx_valid_q;
  assign c0_tx_hdr   = c0_tx_hdr_q;
  assign req_almfull = req_almfull_q;
  assign ovf_err     = ovf_err_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_hdr     = rsp_hdr_q;
  assign rsp_data    = rsp_data_q;

endmodule
